// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   Receives 11-bit PS/2 keyboard frames from the raw ps2_clk/ps2_data lines
//   and buffers the received scan-code bytes in a small FIFO. Parity and
//   framing errors, FIFO overflow and stalled frames are handled here.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   ps2_clk    raw PS/2 clock (asynchronous to clk)
//   ps2_data   raw PS/2 data (asynchronous to clk)
//   rd_en      pop request, honoured only while ready=1
//   data       FIFO head byte, valid while ready=1
//   ready      FIFO non-empty
//   overflow   sticky: good frame arrived while the FIFO was full
//   frame_err  sticky: bad start bit, bad stop bit or parity error
//   clr_flags  synchronous clear of overflow and frame_err
module ps2_rx_fifo #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err,
  input  logic       clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t        state, state_next;
  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [3:0]    count, count_next;
  logic [8:0]    shreg, shreg_next;
  logic [TW-1:0] timer, timer_next;
  logic          fall, bit_in;
  logic          push, bad;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, pop, write, ovf_set;

  // Synchronisers preset to 1 so an idle bus produces no spurious edge.
  // The data path is one flop shorter so the sampled bit lines up with the
  // cycle in which the falling edge is flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign bit_in = data_sync[1];

  // Receiver state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= 4'd0;
      shreg <= 9'd0;
      timer <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      shreg <= shreg_next;
      timer <= timer_next;
    end
  end

  // Next-state logic. The shift register collects d0..d7 and parity
  // LSB-first, so after nine shifts shreg[7:0] is the byte and shreg[8] the
  // parity bit; the stop bit is checked live on the completing edge.
  always_comb begin
    state_next = state;
    count_next = count;
    shreg_next = shreg;
    timer_next = timer;
    push       = 1'b0;
    bad        = 1'b0;
    case (state)
      IDLE: begin
        timer_next = '0;
        if (fall) begin
          if (!bit_in) begin
            state_next = RECV;
            count_next = 4'd1;
          end else begin
            bad = 1'b1;
          end
        end
      end
      RECV: begin
        if (fall) begin
          timer_next = '0;
          if (count == 4'd10) begin
            state_next = IDLE;
            count_next = 4'd0;
            if (bit_in && (^shreg)) push = 1'b1;
            else                    bad  = 1'b1;
          end else begin
            shreg_next = {bit_in, shreg[8:1]};
            count_next = count + 4'd1;
          end
        end else if (timer == TW'(TIMEOUT - 1)) begin
          // Stalled frame: drop it silently and wait for a fresh start bit.
          state_next = IDLE;
          count_next = 4'd0;
          timer_next = '0;
          shreg_next = 9'd0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO status. A pop in the same cycle as a push into a full FIFO frees
  // the slot being written, so the push is accepted without overflow.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rd_en & ~empty;
  assign write   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  // Storage array; contents are meaningless whenever the pointers are equal.
  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr[AW-1:0]] <= shreg[7:0];
  end

  // Pointers and sticky flags; a set event wins over clr_flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (bad)            frame_err <= 1'b1;
      else if (clr_flags) frame_err <= 1'b0;
    end
  end

  assign ready = ~empty;
  assign data  = ready ? mem[rd_ptr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo
//   Self-checking bench for ps2_rx_fifo. A keyboard model drives PS/2 frames
//   (60 clk cycles per bit, data changed while ps2_clk is high); a table of
//   single-frame vectors is followed by hand-written multi-frame sequences.
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_flags = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int compared = 0;
  int mismatched = 0;

  ps2_rx_fifo #(.DEPTH(8), .TIMEOUT(2000)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_flags (clr_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    bit         bad_parity;
    logic       exp_ready;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One PS/2 bit: data set while the clock is high, then a low pulse.
  // With pop_at_edge the bench raises rd_en for exactly the cycle in which
  // the DUT acts on this falling edge (two clk after the raw edge).
  task automatic drive_bit(input logic b, input bit pop_at_edge);
    ps2_data = b;
    repeat (15) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop_at_edge) begin
      repeat (2) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (27) @(negedge clk);
    end else begin
      repeat (30) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] code, input bit bad_parity,
                               input bit pop_at_stop);
    logic par;
    par = ~(^code) ^ bad_parity;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(code[i], 1'b0);
    drive_bit(par, 1'b0);
    drive_bit(1'b1, pop_at_stop);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop_check(input string name, input logic [7:0] expected);
    checkOutput({name, "_ready"}, 32'(ready), 32'd1);
    checkOutput({name, "_data"}, 32'(data), 32'(expected));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 1'b0};
    vecs[2] = '{8'h1C, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{8'h32, 1'b0, 1'b1, 8'h32, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1};

    // Reset state
    repeat (4) @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_data", 32'(data), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table of single frames, each popped before the next
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].code, vecs[i].bad_parity, 1'b0);
      checkOutput($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
      if (vecs[i].exp_ready) begin
        pop_check($sformatf("vec%0d_pop", i), vecs[i].exp_data);
        checkOutput($sformatf("vec%0d_empty", i), 32'(ready), 32'd0);
      end
    end
    pulse_clr();
    checkOutput("clr_ferr", 32'(frame_err), 32'd0);

    // Three frames buffered in order
    applyStimulus(8'h1C, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    pop_check("seq0", 8'h1C);
    pop_check("seq1", 8'hF0);
    pop_check("seq2", 8'h1C);
    checkOutput("seq_empty", 32'(ready), 32'd0);
    checkOutput("seq_ferr", 32'(frame_err), 32'd0);

    // Overflow: nine frames into eight slots
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 1'b0, 1'b0);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) pop_check($sformatf("ovf_pop%0d", i), 8'(i));
    checkOutput("ovf_empty", 32'(ready), 32'd0);
    pulse_clr();
    checkOutput("ovf_clr", 32'(overflow), 32'd0);

    // Stalled partial frame is discarded without an error
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (2100) @(negedge clk);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkOutput("tmo_ferr", 32'(frame_err), 32'd0);
    pop_check("tmo_pop", 8'h1C);
    checkOutput("tmo_empty", 32'(ready), 32'd0);

    // Full FIFO with a pop in the push cycle: push accepted, no overflow
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b0, 1'b0);
    applyStimulus(8'h09, 1'b0, 1'b1);
    checkOutput("fullpop_ovf", 32'(overflow), 32'd0);
    for (int i = 2; i <= 9; i++) pop_check($sformatf("fullpop%0d", i), 8'(i));
    checkOutput("fullpop_empty", 32'(ready), 32'd0);

    // Reset in the middle of a frame
    applyStimulus(8'h1C, 1'b0, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b0);
    checkOutput("prerst_ferr", 32'(frame_err), 32'd1);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", 32'(ready), 32'd0);
    checkOutput("midrst_data", 32'(data), 32'd0);
    checkOutput("midrst_ferr", 32'(frame_err), 32'd0);
    checkOutput("midrst_ovf", 32'(overflow), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkOutput("postrst_ferr", 32'(frame_err), 32'd0);
    pop_check("postrst_pop", 8'h1C);
    checkOutput("postrst_empty", 32'(ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
